// File: rtl/arcade_input_ctrl.sv
// Input conditioning for the game core: PS/2 key state, joystick merge,
// opposite-direction filtering and fixed-width coin pulse generation.
module arcade_input_ctrl #(
  parameter int COIN_PULSE = 200000,
  parameter int COIN_CNT_W = 20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  output logic [1:0]  but_coin_s,
  output logic [1:0]  but_fire_s,
  output logic [1:0]  but_bomb_s,
  output logic [1:0]  but_select_s,
  output logic [1:0]  but_up_s,
  output logic [1:0]  but_down_s,
  output logic [1:0]  but_left_s,
  output logic [1:0]  but_right_s,
  output logic        but_test_s
);

  // Coin FSM states
  //   WAIT_REL | output high, waiting for req to drop (after reset)
  //   IDLE     | output high, armed for the next request
  //   PULSE    | output low, counter running down
  //   HOLD     | output high, waiting for req to drop (after a pulse)
  typedef enum logic [1:0] {S_WAIT_REL, S_IDLE, S_PULSE, S_HOLD} coin_state_e;

  localparam int K_P1_UP = 0,  K_P1_DN = 1,  K_P1_LF = 2,  K_P1_RT = 3;
  localparam int K_P2_UP = 4,  K_P2_DN = 5,  K_P2_LF = 6,  K_P2_RT = 7;
  localparam int K_FIRE1 = 8,  K_FIRE2 = 9,  K_BOMB1 = 10, K_BOMB2 = 11;
  localparam int K_ST1A  = 12, K_ST1B  = 13, K_ST2A  = 14, K_ST2B  = 15;
  localparam int K_COIN1 = 16, K_COIN2 = 17, K_TEST  = 18;
  localparam int NKEYS   = 19;

  localparam logic [COIN_CNT_W-1:0] CNT_LOAD = COIN_CNT_W'(COIN_PULSE - 1);

  logic             toggle_q;
  logic [NKEYS-1:0] key_q, key_d, key_hit;
  logic             ps2_evt;
  logic [1:0]       up_m, dn_m, lf_m, rt_m, fire_m, bomb_m, select_m, coin_req;
  logic [1:0]       up_q, dn_q, lf_q, rt_q, fire_q, bomb_q, select_q, coin_q;
  logic             test_q;

  coin_state_e            state_q [2];
  logic [COIN_CNT_W-1:0]  cnt_q   [2];

  logic unused_joy_bits;
  assign unused_joy_bits = ^{joystick_0[15:8], joystick_1[15:8]};

  // Arrow keys ignore the extended flag; every other key needs it clear.
  always_comb begin
    key_hit = '0;
    case (ps2_key[7:0])
      8'h75: key_hit[K_P1_UP] = 1'b1;
      8'h72: key_hit[K_P1_DN] = 1'b1;
      8'h6B: key_hit[K_P1_LF] = 1'b1;
      8'h74: key_hit[K_P1_RT] = 1'b1;
      8'h2D: key_hit[K_P2_UP] = ~ps2_key[8];
      8'h2B: key_hit[K_P2_DN] = ~ps2_key[8];
      8'h23: key_hit[K_P2_LF] = ~ps2_key[8];
      8'h34: key_hit[K_P2_RT] = ~ps2_key[8];
      8'h14: key_hit[K_FIRE1] = ~ps2_key[8];
      8'h1C: key_hit[K_FIRE2] = ~ps2_key[8];
      8'h29: key_hit[K_BOMB1] = ~ps2_key[8];
      8'h1B: key_hit[K_BOMB2] = ~ps2_key[8];
      8'h05: key_hit[K_ST1A]  = ~ps2_key[8];
      8'h16: key_hit[K_ST1B]  = ~ps2_key[8];
      8'h06: key_hit[K_ST2A]  = ~ps2_key[8];
      8'h1E: key_hit[K_ST2B]  = ~ps2_key[8];
      8'h2E: key_hit[K_COIN1] = ~ps2_key[8];
      8'h36: key_hit[K_COIN2] = ~ps2_key[8];
      8'h2C: key_hit[K_TEST]  = ~ps2_key[8];
      default: ;
    endcase
  end

  assign ps2_evt = ps2_key[10] ^ toggle_q;
  assign key_d   = ps2_evt ? ((key_q & ~key_hit) | (key_hit & {NKEYS{ps2_key[9]}}))
                           : key_q;

  assign up_m   = {key_q[K_P2_UP] | joystick_1[3], key_q[K_P1_UP] | joystick_0[3]};
  assign dn_m   = {key_q[K_P2_DN] | joystick_1[2], key_q[K_P1_DN] | joystick_0[2]};
  assign lf_m   = {key_q[K_P2_LF] | joystick_1[1], key_q[K_P1_LF] | joystick_0[1]};
  assign rt_m   = {key_q[K_P2_RT] | joystick_1[0], key_q[K_P1_RT] | joystick_0[0]};
  assign fire_m = {key_q[K_FIRE2] | joystick_1[4], key_q[K_FIRE1] | joystick_0[4]};
  assign bomb_m = {key_q[K_BOMB2] | joystick_1[5], key_q[K_BOMB1] | joystick_0[5]};

  assign select_m[0] = key_q[K_ST1A] | key_q[K_ST1B] | joystick_0[6] | joystick_1[6];
  assign select_m[1] = key_q[K_ST2A] | key_q[K_ST2B] | joystick_0[7] | joystick_1[7];

  assign coin_req = {key_q[K_COIN2], key_q[K_COIN1] | select_m[0] | select_m[1]};

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      toggle_q <= 1'b0;
      key_q    <= '0;
      up_q     <= 2'b11;
      dn_q     <= 2'b11;
      lf_q     <= 2'b11;
      rt_q     <= 2'b11;
      fire_q   <= 2'b11;
      bomb_q   <= 2'b11;
      select_q <= 2'b11;
      test_q   <= 1'b1;
    end else begin
      toggle_q <= ps2_key[10];
      key_q    <= key_d;
      // Opposing pairs cancel; outputs are active-low.
      up_q     <= ~(up_m & ~dn_m);
      dn_q     <= ~(dn_m & ~up_m);
      lf_q     <= ~(lf_m & ~rt_m);
      rt_q     <= ~(rt_m & ~lf_m);
      fire_q   <= ~fire_m;
      bomb_q   <= ~bomb_m;
      select_q <= ~select_m;
      test_q   <= ~key_q[K_TEST];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= S_WAIT_REL;
        cnt_q[i]   <= '0;
      end
      coin_q <= 2'b11;
    end else begin
      for (int i = 0; i < 2; i++) begin
        coin_q[i] <= (state_q[i] != S_PULSE);
        case (state_q[i])
          S_WAIT_REL, S_HOLD: begin
            if (!coin_req[i]) state_q[i] <= S_IDLE;
          end
          S_IDLE: begin
            if (coin_req[i]) begin
              cnt_q[i]   <= CNT_LOAD;
              state_q[i] <= S_PULSE;
            end
          end
          S_PULSE: begin
            if (cnt_q[i] == '0) state_q[i] <= S_HOLD;
            else                cnt_q[i]   <= cnt_q[i] - 1'b1;
          end
          default: state_q[i] <= S_WAIT_REL;
        endcase
      end
    end
  end

  assign but_coin_s   = coin_q;
  assign but_fire_s   = fire_q;
  assign but_bomb_s   = bomb_q;
  assign but_select_s = select_q;
  assign but_up_s     = up_q;
  assign but_down_s   = dn_q;
  assign but_left_s   = lf_q;
  assign but_right_s  = rt_q;
  assign but_test_s   = test_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed scenarios plus random key/joystick
// traffic, checked every cycle against a key-table reference model.
module tb_arcade_input_ctrl;

  localparam int P = 8;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joystick_0 = '0, joystick_1 = '0;
  logic [1:0]  but_coin_s, but_fire_s, but_bomb_s, but_select_s;
  logic [1:0]  but_up_s, but_down_s, but_left_s, but_right_s;
  logic        but_test_s;

  arcade_input_ctrl #(.COIN_PULSE(P), .COIN_CNT_W(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
    .joystick_0(joystick_0), .joystick_1(joystick_1),
    .but_coin_s(but_coin_s), .but_fire_s(but_fire_s), .but_bomb_s(but_bomb_s),
    .but_select_s(but_select_s), .but_up_s(but_up_s), .but_down_s(but_down_s),
    .but_left_s(but_left_s), .but_right_s(but_right_s), .but_test_s(but_test_s)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: one pressed flag per 9-bit key code, coin as
  // "cycles of low remaining" plus an armed flag.
  bit        pressed [512];
  bit        prev_tog;
  int        left [2];
  bit        armed [2];
  logic [1:0] e_coin = 2'b11, e_fire = 2'b11, e_bomb = 2'b11, e_sel = 2'b11;
  logic [1:0] e_up = 2'b11, e_dn = 2'b11, e_lf = 2'b11, e_rt = 2'b11;
  logic       e_test = 1'b1;
  logic [1:0] m_up, m_dn, m_lf, m_rt, m_fire, m_bomb, m_sel, m_req;
  logic [8:0] m_idx;

  function automatic bit is_arrow(input logic [7:0] c);
    return c == 8'h75 || c == 8'h72 || c == 8'h6B || c == 8'h74;
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) pressed[i] = 1'b0;
      prev_tog = 1'b0;
      for (int i = 0; i < 2; i++) begin left[i] = 0; armed[i] = 1'b0; end
      e_coin = 2'b11; e_fire = 2'b11; e_bomb = 2'b11; e_sel = 2'b11;
      e_up = 2'b11; e_dn = 2'b11; e_lf = 2'b11; e_rt = 2'b11; e_test = 1'b1;
    end else begin
      m_up   = {pressed[9'h02D] | joystick_1[3], pressed[9'h075] | joystick_0[3]};
      m_dn   = {pressed[9'h02B] | joystick_1[2], pressed[9'h072] | joystick_0[2]};
      m_lf   = {pressed[9'h023] | joystick_1[1], pressed[9'h06B] | joystick_0[1]};
      m_rt   = {pressed[9'h034] | joystick_1[0], pressed[9'h074] | joystick_0[0]};
      m_fire = {pressed[9'h01C] | joystick_1[4], pressed[9'h014] | joystick_0[4]};
      m_bomb = {pressed[9'h01B] | joystick_1[5], pressed[9'h029] | joystick_0[5]};
      m_sel[0] = pressed[9'h005] | pressed[9'h016] | joystick_0[6] | joystick_1[6];
      m_sel[1] = pressed[9'h006] | pressed[9'h01E] | joystick_0[7] | joystick_1[7];
      m_req  = {pressed[9'h036], pressed[9'h02E] | m_sel[0] | m_sel[1]};
      for (int p = 0; p < 2; p++) begin
        e_up[p] = !(m_up[p] && !m_dn[p]);
        e_dn[p] = !(m_dn[p] && !m_up[p]);
        e_lf[p] = !(m_lf[p] && !m_rt[p]);
        e_rt[p] = !(m_rt[p] && !m_lf[p]);
      end
      e_fire = ~m_fire; e_bomb = ~m_bomb; e_sel = ~m_sel;
      e_test = !pressed[9'h02C];
      for (int i = 0; i < 2; i++) begin
        e_coin[i] = (left[i] == 0);
        if (left[i] > 0) left[i]--;
        else if (!m_req[i]) armed[i] = 1'b1;
        else if (armed[i]) begin left[i] = P; armed[i] = 1'b0; end
      end
      if (ps2_key[10] != prev_tog) begin
        m_idx = ps2_key[8:0];
        if (is_arrow(ps2_key[7:0])) m_idx[8] = 1'b0;
        pressed[m_idx] = ps2_key[9];
      end
      prev_tog = ps2_key[10];
    end
  end

  bit started = 1'b0;
  initial begin @(posedge clk_sys); started = 1'b1; end

  always @(negedge clk_sys) begin
    if (started) begin
      check("coin",   32'(but_coin_s),   32'(e_coin));
      check("fire",   32'(but_fire_s),   32'(e_fire));
      check("bomb",   32'(but_bomb_s),   32'(e_bomb));
      check("select", 32'(but_select_s), 32'(e_sel));
      check("up",     32'(but_up_s),     32'(e_up));
      check("down",   32'(but_down_s),   32'(e_dn));
      check("left",   32'(but_left_s),   32'(e_lf));
      check("right",  32'(but_right_s),  32'(e_rt));
      check("test",   32'(but_test_s),   32'(e_test));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #2;
  endtask

  task automatic key(input logic [8:0] code, input bit down);
    ps2_key = {~ps2_key[10], down, code};
  endtask

  task automatic count_low(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge clk_sys);
      if (!but_coin_s[0]) n++;
    end
  endtask

  task automatic wait_coin_low(output int n);
    int w = 0;
    while (but_coin_s[0] && w < 30) begin @(negedge clk_sys); w++; end
    check("coin_pulse_started", 32'(but_coin_s[0]), 32'd0);
    n = 1;
  endtask

  logic [8:0] codes [19] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h02D, 9'h02B, 9'h023,
                             9'h034, 9'h014, 9'h01C, 9'h029, 9'h01B, 9'h005, 9'h016,
                             9'h006, 9'h01E, 9'h02E, 9'h036, 9'h02C};

  initial begin
    int n;
    logic [8:0] c;
    // Reset with start1 held: no coin until the request drops.
    joystick_0 = 16'h0040;
    tick(3);
    check("reset_all_ones", 32'({but_coin_s, but_fire_s, but_bomb_s, but_select_s, but_up_s,
                                 but_down_s, but_left_s, but_right_s, but_test_s}), 32'h1FFFF);
    reset = 1'b0;
    tick(20);
    check("wait_rel_coin0", 32'(but_coin_s[0]), 32'd1);
    joystick_0 = 16'h0000;
    tick(3);
    joystick_0 = 16'h0040;
    count_low(30, n);
    check("start_coin_width", 32'(n), 32'(P));
    joystick_0 = 16'h0000;
    tick(5);

    // Keyboard up press/release latency.
    key(9'h075, 1'b1);
    @(negedge clk_sys); check("press_pre_edge1", 32'(but_up_s), 32'b11);
    @(negedge clk_sys); check("press_after_edge1", 32'(but_up_s), 32'b11);
    @(negedge clk_sys); check("press_after_edge2", 32'(but_up_s), 32'b10);
    check("press_others_idle", 32'({but_coin_s, but_fire_s, but_bomb_s, but_select_s,
                                    but_down_s, but_left_s, but_right_s, but_test_s}), 32'h7FFF);
    @(posedge clk_sys); #2;
    tick(8);
    key(9'h075, 1'b0);
    @(negedge clk_sys); check("release_pre_edge1", 32'(but_up_s), 32'b10);
    @(negedge clk_sys); check("release_after_edge1", 32'(but_up_s), 32'b10);
    @(negedge clk_sys); check("release_after_edge2", 32'(but_up_s), 32'b11);
    @(posedge clk_sys); #2;

    // Opposite-direction filter on player 2.
    joystick_1 = 16'h000C; tick(1);
    @(negedge clk_sys);
    check("updown_up", 32'(but_up_s), 32'b11);
    check("updown_down", 32'(but_down_s), 32'b11);
    @(posedge clk_sys); #2;
    joystick_1 = 16'h0009; tick(1);
    @(negedge clk_sys);
    check("diag_up", 32'(but_up_s), 32'b01);
    check("diag_right", 32'(but_right_s), 32'b01);
    @(posedge clk_sys); #2;
    joystick_1 = 16'h0003; tick(1);
    @(negedge clk_sys);
    check("leftright_left", 32'(but_left_s), 32'b11);
    check("leftright_right", 32'(but_right_s), 32'b11);
    @(posedge clk_sys); #2;
    joystick_1 = 16'h0000; tick(2);

    // Coin key held: one pulse; re-press gives another.
    key(9'h02E, 1'b1);
    count_low(100, n);
    check("coin_hold_one_pulse", 32'(n), 32'(P));
    key(9'h02E, 1'b0); tick(3);
    key(9'h02E, 1'b1);
    count_low(30, n);
    check("coin_second_pulse", 32'(n), 32'(P));
    key(9'h02E, 1'b0); tick(3);

    // Request dropped during the pulse.
    key(9'h02E, 1'b1);
    wait_coin_low(n);
    repeat (2) begin @(negedge clk_sys); if (!but_coin_s[0]) n++; end
    key(9'h02E, 1'b0);
    repeat (20) begin @(negedge clk_sys); if (!but_coin_s[0]) n++; end
    check("coin_drop_midpulse", 32'(n), 32'(P));
    tick(3);

    // Reset mid-pulse releases the coin line asynchronously.
    key(9'h02E, 1'b1);
    wait_coin_low(n);
    repeat (4) @(negedge clk_sys);
    check("coin_low_cycle5", 32'(but_coin_s[0]), 32'd0);
    #2 reset = 1'b1;
    #1 check("coin_async_reset", 32'(but_coin_s[0]), 32'd1);
    tick(2);
    key(9'h02E, 1'b0);
    reset = 1'b0;
    tick(3);

    // Player separation.
    joystick_0 = 16'h0010; joystick_1 = 16'h0000; tick(1);
    @(negedge clk_sys); check("fire_p1_only", 32'(but_fire_s), 32'b10);
    @(posedge clk_sys); #2;
    key(9'h01C, 1'b1); tick(2);
    @(negedge clk_sys); check("fire_both", 32'(but_fire_s), 32'b00);
    @(posedge clk_sys); #2;
    key(9'h01C, 1'b0); joystick_0 = 16'h0000; tick(3);

    // Random traffic against the model.
    repeat (3000) begin
      if ($urandom_range(0, 99) < 30) begin
        if ($urandom_range(0, 9) == 0) c = 9'($urandom);
        else begin
          c = codes[$urandom_range(0, 18)];
          if ($urandom_range(0, 9) < 2 || is_arrow(c[7:0])) c[8] = 1'($urandom);
        end
        key(c, 1'($urandom));
      end
      if ($urandom_range(0, 99) < 5) joystick_0 = 16'($urandom) & 16'hFF3F;
      if ($urandom_range(0, 99) < 5) joystick_1 = 16'($urandom) & 16'hFF3F;
      if ($urandom_range(0, 99) < 2) joystick_0[7:6] = 2'($urandom);
      reset = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
